// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Pipeline boundary register with a valid/ready handshake and a 2-entry
//   skid buffer. Carries instr, PC, destination register, Tnew and NCH
//   packed data channels. Supports flush, bubble insertion on drain and an
//   optional Tnew ageing mode for entries that sit in the stage.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   flush             drop every held entry (synchronous)
//   in_valid/in_ready upstream handshake; in_ready is registered (= !skid)
//   in_instr, in_pc, in_dst, in_tnew, in_data   upstream entry fields
//   out_valid/out_ready downstream handshake
//   out_instr, out_pc, out_dst, out_tnew, out_data  fields of the main reg
//
// Storage: main register M drives out_*; skid register S catches the entry
// accepted while M is stalled. S only ever fills behind a valid M, so
// ordering is strict FIFO and occupancy never exceeds 2.

module pipe_stage_skid_reg #(
   parameter int          DATA_W      = 32,
   parameter int          NCH         = 3,
   parameter int          TNEW_W      = 3,
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter int          AGE_ON_HOLD = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [31:0]           in_pc,
   input  logic [4:0]            in_dst,
   input  logic [TNEW_W-1:0]     in_tnew,
   input  logic [NCH*DATA_W-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_instr,
   output logic [31:0]           out_pc,
   output logic [4:0]            out_dst,
   output logic [TNEW_W-1:0]     out_tnew,
   output logic [NCH*DATA_W-1:0] out_data
);

   localparam int              DW       = NCH * DATA_W;
   localparam logic [TNEW_W-1:0] TNEW_ONE = TNEW_W'(1);

   // saturating decrement: Tnew never wraps below zero
   function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
      return (x == '0) ? '0 : (x - TNEW_ONE);
   endfunction

   logic              r_m_valid;
   logic [31:0]       r_m_instr;
   logic [31:0]       r_m_pc;
   logic [4:0]        r_m_dst;
   logic [TNEW_W-1:0] r_m_tnew;
   logic [DW-1:0]     r_m_data;

   logic              r_s_valid;
   logic [31:0]       r_s_instr;
   logic [31:0]       r_s_pc;
   logic [4:0]        r_s_dst;
   logic [TNEW_W-1:0] r_s_tnew;
   logic [DW-1:0]     r_s_data;

   logic              w_acc;
   logic              w_m_free;
   logic [TNEW_W-1:0] w_in_tnew;
   logic [TNEW_W-1:0] w_m_tnew_held;
   logic [TNEW_W-1:0] w_s_tnew_aged;

   // in_ready comes straight from the skid valid flop, so out_ready has no
   // combinational path to in_ready.
   assign in_ready  = ~r_s_valid;
   assign w_acc     = in_valid & ~r_s_valid;
   // M can take a new value when it is empty or its entry leaves this cycle
   assign w_m_free  = ~r_m_valid | out_ready;
   assign w_in_tnew = sat_dec(in_tnew);

   // With ageing on, a held entry and an S->M transfer both lose one cycle.
   assign w_m_tnew_held = (AGE_ON_HOLD != 0) ? sat_dec(r_m_tnew) : r_m_tnew;
   assign w_s_tnew_aged = (AGE_ON_HOLD != 0) ? sat_dec(r_s_tnew) : r_s_tnew;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_m_valid <= 1'b0;
         r_m_instr <= '0;
         r_m_pc    <= RESET_PC;
         r_m_dst   <= '0;
         r_m_tnew  <= '0;
         r_m_data  <= '0;
         r_s_valid <= 1'b0;
         r_s_instr <= '0;
         r_s_pc    <= '0;
         r_s_dst   <= '0;
         r_s_tnew  <= '0;
         r_s_data  <= '0;
      end else if (flush) begin
         // data channels are left untouched on flush
         r_m_valid <= 1'b0;
         r_m_instr <= '0;
         r_m_pc    <= RESET_PC;
         r_m_dst   <= '0;
         r_m_tnew  <= '0;
         r_s_valid <= 1'b0;
      end else if (w_m_free) begin
         if (r_s_valid) begin
            r_m_valid <= 1'b1;
            r_m_instr <= r_s_instr;
            r_m_pc    <= r_s_pc;
            r_m_dst   <= r_s_dst;
            r_m_tnew  <= w_s_tnew_aged;
            r_m_data  <= r_s_data;
            r_s_valid <= 1'b0;
         end else if (w_acc) begin
            r_m_valid <= 1'b1;
            r_m_instr <= in_instr;
            r_m_pc    <= in_pc;
            r_m_dst   <= in_dst;
            r_m_tnew  <= w_in_tnew;
            r_m_data  <= in_data;
         end else begin
            // bubble: NOP fields cleared, pc and data keep their last value
            r_m_valid <= 1'b0;
            r_m_instr <= '0;
            r_m_dst   <= '0;
            r_m_tnew  <= '0;
         end
      end else begin
         r_m_tnew <= w_m_tnew_held;
         if (w_acc) begin
            r_s_valid <= 1'b1;
            r_s_instr <= in_instr;
            r_s_pc    <= in_pc;
            r_s_dst   <= in_dst;
            r_s_tnew  <= w_in_tnew;
            r_s_data  <= in_data;
         end else if (r_s_valid) begin
            r_s_tnew <= w_s_tnew_aged;
         end
      end
   end

   assign out_valid = r_m_valid;
   assign out_instr = r_m_instr;
   assign out_pc    = r_m_pc;
   assign out_dst   = r_m_dst;
   assign out_tnew  = r_m_tnew;
   assign out_data  = r_m_data;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg
//   Drives two instances (AGE_ON_HOLD = 0 and 1) from the same inputs and
//   checks them against a queue-based model of the stage: up to two entries
//   in FIFO order, head visible on the outputs, Tnew tracked per ageing mode.

module tb_pipe_stage_skid_reg;

   localparam int DATA_W = 32;
   localparam int NCH    = 3;
   localparam int TW     = 3;
   localparam int DW     = NCH * DATA_W;
   localparam logic [31:0] RPC = 32'h0000_3000;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [31:0]   in_instr, in_pc;
   logic [4:0]    in_dst;
   logic [TW-1:0] in_tnew;
   logic [DW-1:0] in_data;

   logic          o0_in_ready, o0_valid, o1_in_ready, o1_valid;
   logic [31:0]   o0_instr, o0_pc, o1_instr, o1_pc;
   logic [4:0]    o0_dst, o1_dst;
   logic [TW-1:0] o0_tnew, o1_tnew;
   logic [DW-1:0] o0_data, o1_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage_skid_reg #(.DATA_W(DATA_W), .NCH(NCH), .TNEW_W(TW),
                         .RESET_PC(RPC), .AGE_ON_HOLD(0)) u_dut0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(o0_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_dst(in_dst),
      .in_tnew(in_tnew), .in_data(in_data),
      .out_valid(o0_valid), .out_ready(out_ready),
      .out_instr(o0_instr), .out_pc(o0_pc), .out_dst(o0_dst),
      .out_tnew(o0_tnew), .out_data(o0_data));

   pipe_stage_skid_reg #(.DATA_W(DATA_W), .NCH(NCH), .TNEW_W(TW),
                         .RESET_PC(RPC), .AGE_ON_HOLD(1)) u_dut1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(o1_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_dst(in_dst),
      .in_tnew(in_tnew), .in_data(in_data),
      .out_valid(o1_valid), .out_ready(out_ready),
      .out_instr(o1_instr), .out_pc(o1_pc), .out_dst(o1_dst),
      .out_tnew(o1_tnew), .out_data(o1_data));

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0]   instr;
      logic [31:0]   pc;
      logic [4:0]    dst;
      logic [TW-1:0] tnew0;
      logic [TW-1:0] tnew1;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        mq[$];
   logic [31:0]   m_last_pc   = RPC;
   logic [DW-1:0] m_last_data = '0;

   function automatic logic [TW-1:0] sdm(input logic [TW-1:0] x);
      return (x == 0) ? TW'(0) : TW'(x - 1);
   endfunction

   // one clock: decide handshakes from current state/inputs, then advance
   task automatic tick();
      bit     acc, fire;
      entry_t e;
      acc  = in_valid && (mq.size() < 2);
      fire = out_ready && (mq.size() > 0);
      e.instr = in_instr; e.pc = in_pc; e.dst = in_dst; e.data = in_data;
      e.tnew0 = sdm(in_tnew); e.tnew1 = sdm(in_tnew);
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_last_pc   = RPC;
         m_last_data = '0;
      end else if (flush) begin
         mq.delete();
         m_last_pc = RPC;
      end else begin
         if (fire) void'(mq.pop_front());
         // every entry that stays in the stage ages one cycle (mode 1 only)
         foreach (mq[i]) mq[i].tnew1 = sdm(mq[i].tnew1);
         if (acc) mq.push_back(e);
         if (mq.size() > 0) begin
            m_last_pc   = mq[0].pc;
            m_last_data = mq[0].data;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      reset = 0; flush = 0; in_valid = 0; out_ready = 0;
      in_instr = '0; in_pc = '0; in_dst = '0; in_tnew = '0; in_data = '0;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [4:0] dst, input logic [TW-1:0] tnew,
                        input logic [DW-1:0] data);
      in_valid = 1; in_instr = instr; in_pc = pc; in_dst = dst;
      in_tnew = tnew; in_data = data;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      reset = 1; in_valid = 1; in_instr = 32'hDEAD_BEEF;
      tick(); tick();
      reset = 0; in_valid = 0;
      checks++;
      if ({o0_valid, o0_instr, o0_pc, o0_dst, o0_tnew, o0_in_ready} !==
          {1'b0, 32'h0, RPC, 5'h0, 3'h0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state v=%0b instr=%h pc=%h dst=%0d tnew=%0d rdy=%0b exp v=0 instr=0 pc=%h dst=0 tnew=0 rdy=1",
                  o0_valid, o0_instr, o0_pc, o0_dst, o0_tnew, o0_in_ready, RPC);
      end
      checks++;
      if (o0_data !== '0 || o1_pc !== RPC) begin
         errors++;
         $display("FAIL reset_data data=%h pc1=%h exp data=0 pc1=%h", o0_data, o1_pc, RPC);
      end
      tick();
      checks++;
      if (o0_valid !== 1'b0 || o0_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release v=%0b rdy=%0b exp v=0 rdy=1", o0_valid, o0_in_ready);
      end
   endtask

   task automatic test_stream();
      logic [31:0] ins [3];
      ins[0] = 32'h8C01_0004; ins[1] = 32'h0022_1820; ins[2] = 32'hAC03_0008;
      idle_inputs();
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         drive(ins[i], 32'h3000 + 32'(4 * i), 5'(i + 1), 3'd2, DW'(i));
         tick();
         checks++;
         if (o0_valid !== 1'b1 || o0_instr !== ins[i] || o0_tnew !== 3'd1 ||
             o1_tnew !== 3'd1 || o0_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_%0d v=%0b instr=%h tnew=%0d/%0d rdy=%0b exp v=1 instr=%h tnew=1/1 rdy=1",
                     i, o0_valid, o0_instr, o0_tnew, o1_tnew, o0_in_ready, ins[i]);
         end
      end
      in_valid = 0;
      tick();
      checks++;
      if (o0_valid !== 1'b0 || o0_instr !== 32'h0 || o0_pc !== 32'h3008) begin
         errors++;
         $display("FAIL stream_bubble v=%0b instr=%h pc=%h exp v=0 instr=0 pc=00003008",
                  o0_valid, o0_instr, o0_pc);
      end
   endtask

   task automatic test_backpressure();
      idle_inputs();
      drive(32'h1111_1111, 32'h100, 5'd1, 3'd0, DW'(1));
      tick();
      checks++;
      if (o0_instr !== 32'h1111_1111 || o0_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first instr=%h rdy=%0b exp instr=11111111 rdy=1", o0_instr, o0_in_ready);
      end
      drive(32'h2222_2222, 32'h104, 5'd2, 3'd0, DW'(2));
      tick();
      checks++;
      if (o0_instr !== 32'h1111_1111 || o0_in_ready !== 1'b0 || o1_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full instr=%h rdy=%0b/%0b exp instr=11111111 rdy=0/0",
                  o0_instr, o0_in_ready, o1_in_ready);
      end
      drive(32'h3333_3333, 32'h108, 5'd3, 3'd0, DW'(3));
      tick();
      checks++;
      if (o0_instr !== 32'h1111_1111 || o0_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold instr=%h rdy=%0b exp instr=11111111 rdy=0", o0_instr, o0_in_ready);
      end
      in_valid = 0; out_ready = 1;
      tick();
      checks++;
      if (o0_valid !== 1'b1 || o0_instr !== 32'h2222_2222 || o0_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_second v=%0b instr=%h rdy=%0b exp v=1 instr=22222222 rdy=1",
                  o0_valid, o0_instr, o0_in_ready);
      end
      tick();
      checks++;
      if (o0_valid !== 1'b0 || o0_instr !== 32'h0) begin
         errors++;
         $display("FAIL bp_third_dropped v=%0b instr=%h exp v=0 instr=0", o0_valid, o0_instr);
      end
   endtask

   task automatic test_tnew_age();
      logic [TW-1:0] exp1 [4];
      exp1[0] = 3'd2; exp1[1] = 3'd1; exp1[2] = 3'd0; exp1[3] = 3'd0;
      idle_inputs();
      drive(32'h4444_4444, 32'h200, 5'd4, 3'd3, DW'(4));
      for (int i = 0; i < 4; i++) begin
         tick();
         in_valid = 0;
         checks++;
         if (o1_tnew !== exp1[i] || o0_tnew !== 3'd2) begin
            errors++;
            $display("FAIL tnew_age_%0d age1=%0d age0=%0d exp age1=%0d age0=2",
                     i, o1_tnew, o0_tnew, exp1[i]);
         end
      end
      out_ready = 1;
      tick();
   endtask

   task automatic test_flush();
      idle_inputs();
      drive(32'h5555_5555, 32'h300, 5'd5, 3'd4, DW'(5));
      tick();
      drive(32'h6666_6666, 32'h304, 5'd6, 3'd4, DW'(6));
      tick();
      drive(32'h7777_7777, 32'h308, 5'd7, 3'd4, DW'(7));
      flush = 1;
      tick();
      flush = 0; in_valid = 0;
      checks++;
      if ({o0_valid, o0_instr, o0_dst, o0_pc, o0_tnew, o0_in_ready} !==
          {1'b0, 32'h0, 5'h0, RPC, 3'h0, 1'b1}) begin
         errors++;
         $display("FAIL flush_full v=%0b instr=%h dst=%0d pc=%h tnew=%0d rdy=%0b exp v=0 instr=0 dst=0 pc=%h tnew=0 rdy=1",
                  o0_valid, o0_instr, o0_dst, o0_pc, o0_tnew, o0_in_ready, RPC);
      end
      checks++;
      if (o0_data !== DW'(5)) begin
         errors++;
         $display("FAIL flush_data_kept data=%h exp %h", o0_data, DW'(5));
      end
      out_ready = 1;
      tick();
      checks++;
      if (o0_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_resurrect v=%0b exp 0", o0_valid);
      end
      // flush while in_ready=1: the coinciding accept must also be dropped
      out_ready = 0;
      drive(32'h8888_8888, 32'h400, 5'd8, 3'd1, DW'(8));
      tick();
      drive(32'h9999_9999, 32'h404, 5'd9, 3'd1, DW'(9));
      flush = 1;
      tick();
      flush = 0; in_valid = 0; out_ready = 1;
      tick();
      checks++;
      if (o0_valid !== 1'b0 || o0_instr !== 32'h0) begin
         errors++;
         $display("FAIL flush_drop_acc v=%0b instr=%h exp v=0 instr=0", o0_valid, o0_instr);
      end
   endtask

   task automatic test_data_channels();
      idle_inputs();
      drive(32'hABCD_0001, 32'h500, 5'd10, 3'd5, {32'hC, 32'hB, 32'hA});
      tick();
      checks++;
      if (o0_data[0 +: 32] !== 32'hA || o0_data[32 +: 32] !== 32'hB ||
          o0_data[64 +: 32] !== 32'hC) begin
         errors++;
         $display("FAIL data_channels ch0=%h ch1=%h ch2=%h exp A B C",
                  o0_data[0 +: 32], o0_data[32 +: 32], o0_data[64 +: 32]);
      end
      drive(32'hABCD_0002, 32'h504, 5'd11, 3'd5, {32'hF, 32'hE, 32'hD});
      tick();
      in_valid = 0; reset = 1;
      tick();
      reset = 0;
      checks++;
      if ({o0_valid, o0_instr, o0_pc, o0_dst, o0_tnew, o0_data, o0_in_ready} !==
          {1'b0, 32'h0, RPC, 5'h0, 3'h0, {DW{1'b0}}, 1'b1}) begin
         errors++;
         $display("FAIL reset_while_full v=%0b instr=%h pc=%h dst=%0d tnew=%0d data=%h rdy=%0b exp reset values",
                  o0_valid, o0_instr, o0_pc, o0_dst, o0_tnew, o0_data, o0_in_ready);
      end
   endtask

   task automatic test_random();
      logic [169:0] exp0, exp1, act0, act1;
      entry_t       h;
      bit           v;
      idle_inputs();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_instr  = $urandom; in_pc = $urandom; in_dst = 5'($urandom);
         in_tnew   = TW'($urandom);
         in_data   = {$urandom, $urandom, $urandom};
         tick();
         v = (mq.size() > 0);
         if (v) h = mq[0];
         else begin
            h.instr = '0; h.dst = '0; h.tnew0 = '0; h.tnew1 = '0;
         end
         exp0 = {v, h.instr, m_last_pc, h.dst, h.tnew0, m_last_data, mq.size() < 2};
         exp1 = {v, h.instr, m_last_pc, h.dst, h.tnew1, m_last_data, mq.size() < 2};
         act0 = {o0_valid, o0_instr, o0_pc, o0_dst, o0_tnew, o0_data, o0_in_ready};
         act1 = {o1_valid, o1_instr, o1_pc, o1_dst, o1_tnew, o1_data, o1_in_ready};
         checks++;
         if (act0 !== exp0) begin
            errors++;
            $display("FAIL rand_age0 cyc=%0d got %h exp %h", c, act0, exp0);
         end
         checks++;
         if (act1 !== exp1) begin
            errors++;
            $display("FAIL rand_age1 cyc=%0d got %h exp %h", c, act1, exp1);
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_stream();
      test_backpressure();
      test_tnew_age();
      test_flush();
      test_data_channels();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed M/W pipeline register.
- Carries instr, PC, destination register, Tnew and NCH packed data channels between two pipeline stages.
- Adds a valid/ready handshake with a 2-entry skid buffer (registered in_ready), flush, bubble generation and an optional Tnew ageing mode.
- Used for the M/W boundary and for any future stage boundary that may back-pressure (multi-cycle MDU, cache miss).

Parameters:
- DATA_W, 32, width of one data channel
- NCH, 3, number of data channels (e.g. RD, ALU result, WD)
- TNEW_W, 3, width of the Tnew field
- RESET_PC, 32'h0000_3000, PC value presented after reset/flush
- AGE_ON_HOLD, 0, 1 = Tnew also decrements every cycle an entry is held

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all held entries (synchronous)
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; registered, equals NOT skid_valid
- in_instr  in  32  instruction word
- in_pc  in  32  PC
- in_dst  in  5  destination register number
- in_tnew  in  TNEW_W  cycles until result ready, as seen upstream
- in_data  in  NCH*DATA_W  packed channels, channel k at [k*DATA_W +: DATA_W]
- out_valid  out  1  main register holds an entry
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction, 0 (NOP) when out_valid=0
- out_pc  out  32  PC of held entry
- out_dst  out  5  destination, 0 when out_valid=0
- out_tnew  out  TNEW_W  Tnew, 0 when out_valid=0
- out_data  out  NCH*DATA_W  data channels

Behaviour:
- Reset and clock: reset/clk as already decided — reset reset, synchronous, active-high; clock clk.
- Storage: main register M (drives out_*) and skid register S, each with a valid bit.
- acc = in_valid & in_ready; fire = out_valid & out_ready.
- Reset values: M and S invalid; out_instr=0, out_pc=RESET_PC, out_dst=0, out_tnew=0, out_data=0, out_valid=0. in_ready=1 from the first cycle after reset.
- Priority: reset > flush > normal operation.
- Flush: M and S invalid; instr/dst/tnew=0; pc=RESET_PC; data unchanged. Any acc in the same cycle is dropped. in_ready=1 in the next cycle.
- Normal operation, M empty or fire:
  - S valid: M<=S, S invalid (in_ready is 0, so no acc is possible).
  - Else if acc: M<=input.
  - Else: M becomes invalid and instr/dst/tnew are cleared to 0 (bubble); pc and data hold.
- Normal operation, M valid and not fire: if acc, S<=input, so in_ready drops in the next cycle. M holds.
- Latency: 1 cycle from acc to out_valid when the stage is empty. Full throughput: 1 entry/cycle while out_ready=1. No combinational path from out_ready to in_ready.
- Ordering: strict FIFO; S never overtakes M. Maximum occupancy is 2.
- Tnew, with sd(x) = (x==0) ? 0 : x-1:
  - On load from input, the stored value is sd(in_tnew).
  - AGE_ON_HOLD=1: every cycle an entry stays in M or S it becomes sd(value). An S->M transfer also applies sd once.
  - AGE_ON_HOLD=0: the value is unchanged while held; an S->M transfer copies it unchanged.
- Widths: all fields pass through unmodified except Tnew. Tnew never wraps below 0.
- Ready/valid violations: in_valid while in_ready=0 is ignored (upstream holds). out_ready while out_valid=0 has no effect.

Test Plan:
1. Reset for 2 cycles, then release -> out_valid=0, out_pc=32'h3000, out_instr=0, out_tnew=0, in_ready=1.
2. Stream instr 0x8C010004, 0x00221820, 0xAC030008 with tnew=2 and out_ready=1 -> each appears one cycle after acc with out_tnew=1; no bubbles; in_ready stays 1.
3. out_ready=0 while 2 entries are pushed:
   - in_ready falls the cycle after the 2nd acc.
   - A 3rd in_valid is not accepted.
   - Raising out_ready delivers entries 1 then 2 on consecutive cycles.
   - in_ready returns to 1 one cycle after entry 1 fires.
4. AGE_ON_HOLD=1: push in_tnew=3, out_ready=0 for 4 cycles -> out_tnew 2, 1, 0, 0 (saturates). With AGE_ON_HOLD=0 -> out_tnew stays 2.
5. Both M and S full, assert flush together with in_valid=1 -> next cycle out_valid=0, out_instr=0, out_dst=0, out_pc=32'h3000, in_ready=1; the incoming entry does not appear.
6. NCH=3, DATA_W=32, out_ready=0 for 1 cycle, in_data={32'hC,32'hB,32'hA} -> out_data channels 0, 1, 2 = 0xA, 0xB, 0xC; then reset asserted while full -> all outputs return to their reset values on the next cycle.
